// File: rtl/mdu_pkg.sv
// Multiply/divide unit shared definitions: op codes, FSM states, cycle defaults.
package mdu_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic is_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational HI/LO result for MULT/MULTU and, with MDU_DIV_EN, DIV/DIVU.
// The divider exists only when MDU_DIV_EN is defined.
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [63:0] res
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;

    assign prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    assign prod_u = {32'b0, rs_val} * {32'b0, rt_val};

`ifdef MDU_DIV_EN
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] sq;
    logic [31:0] sr;
    logic [63:0] div_res;

    // Divide magnitudes, then restore signs: quotient truncates toward zero,
    // remainder follows the dividend.
    assign sgn = (op == OP_DIV);
    assign a   = (sgn && rs_val[31]) ? -rs_val : rs_val;
    assign b   = (sgn && rt_val[31]) ? -rt_val : rt_val;
    assign uq  = (b == 32'd0) ? 32'd0 : a / b;
    assign ur  = (b == 32'd0) ? 32'd0 : a % b;
    assign sq  = (sgn && (rs_val[31] ^ rt_val[31])) ? -uq : uq;
    assign sr  = (sgn && rs_val[31]) ? -ur : ur;

    assign div_res = (rt_val == 32'd0) ? {rs_val, 32'hFFFF_FFFF}
                                       : {sr, sq};
`endif

    always_comb begin
        res = '0;
        case (op)
            OP_MULT:  res = prod_s;
            OP_MULTU: res = prod_u;
`ifdef MDU_DIV_EN
            OP_DIV,
            OP_DIVU:  res = div_res;
`endif
            default:  res = '0;
        endcase
    end

endmodule

// File: rtl/mdu_unit.sv
// HI/LO multiply/divide unit: IDLE/RUN FSM with fixed-latency result commit.
// Divide support is built only when MDU_DIV_EN is defined.
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] MC = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DC = CW'(DIV_CYCLES);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   p_hi;
    logic [31:0]   p_lo;
    logic [63:0]   res;
    logic          md_op;
    logic [CW-1:0] load;

    mdu_calc u_calc (
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .res    (res)
    );

    always_comb begin
        md_op = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MDU_DIV_EN
        md_op = md_op || is_div(op);
`endif
    end

    assign load = is_div(op) ? DC : MC;
    assign busy = (state == RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            p_hi  <= '0;
            p_lo  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (md_op) begin
                            p_hi  <= res[63:32];
                            p_lo  <= res[31:0];
                            cnt   <= load;
                            state <= RUN;
                        end else if (op == OP_MTHI) begin
                            hi <= rs_val;
                        end else if (op == OP_MTLO) begin
                            lo <= rs_val;
                        end
                    end
                end
                RUN: begin
                    // Requests arriving here are dropped; the hazard unit stalls.
                    cnt <= cnt - CW'(1);
                    if (cnt <= CW'(1)) begin
                        cnt   <= '0;
                        hi    <= p_hi;
                        lo    <= p_lo;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Randomized self-checking bench for mdu_unit against an arithmetic model.
// Follows MDU_DIV_EN to pick divide or no-op expectations.
module tb_mdu_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks;
    int failures;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mdu_unit dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_cycles(input logic [2:0] o);
        case (o)
            3'd0, 3'd1: return 5;
`ifdef MDU_DIV_EN
            3'd2, 3'd3: return 10;
`endif
            default:    return 0;
        endcase
    endfunction

    function automatic logic [63:0] ref_res(input logic [2:0] o,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, q, r;
        longint unsigned ua, ub;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        q  = 0;
        r  = 0;
        case (o)
            3'd0: return 64'(sa * sb);
            3'd1: return 64'(ua * ub);
            3'd2, 3'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (o == 3'd2) begin
                    q = sa / sb;
                    r = sa % sb;
                end else begin
                    q = longint'(ua / ub);
                    r = longint'(ua % ub);
                end
                return {r[31:0], q[31:0]};
            end
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 9));
            default: return $urandom;
        endcase
    endfunction

    // Entered and left at a negedge; the next op may launch immediately.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input bit poke,
                         input logic [2:0] pop, input logic [31:0] pval);
        int n;
        logic [63:0] r;
        logic [31:0] oh, ol;
        n  = ref_cycles(o);
        r  = ref_res(o, a, b);
        oh = m_hi;
        ol = m_lo;
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        @(negedge clk);
        start = 1'b0;
        if (n == 0) begin
            if (o == 3'd4) m_hi = a;
            else if (o == 3'd5) m_lo = a;
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_hi", hi, m_hi);
            check("idle_lo", lo, m_lo);
        end else begin
            for (int i = 1; i <= n; i++) begin
                check("run_busy", 32'(busy), 32'd1);
                check("run_hi_hold", hi, oh);
                check("run_lo_hold", lo, ol);
                if (poke && i == 2) begin
                    start  = 1'b1;
                    op     = pop;
                    rs_val = pval;
                    rt_val = $urandom;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
            end
            start = 1'b0;
            m_hi = r[63:32];
            m_lo = r[31:0];
            check("done_busy", 32'(busy), 32'd0);
            check("done_hi", hi, m_hi);
            check("done_lo", lo, m_lo);
        end
    endtask

    task automatic reset_mid_op();
        start  = 1'b1;
        op     = 3'd2;
        rs_val = 32'd100;
        rt_val = 32'd7;
        @(negedge clk);
        start = 1'b0;
        op    = 3'd0;
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
        reset = 1'b0;
        repeat (12) begin
            @(negedge clk);
            check("post_rst_busy", 32'(busy), 32'd0);
            check("post_rst_hi", hi, 32'd0);
            check("post_rst_lo", lo, 32'd0);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        m_hi     = 32'd0;
        m_lo     = 32'd0;
        reset    = 1'b1;
        start    = 1'b0;
        op       = 3'd0;
        rs_val   = 32'd0;
        rt_val   = 32'd0;

        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        do_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, 3'd0, 32'd0);
        do_op(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 3'd0, 32'd0);
        do_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 3'd0, 32'd0);
        do_op(3'd3, 32'd7, 32'd0, 1'b0, 3'd0, 32'd0);
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 3'd0, 32'd0);
        do_op(3'd2, 32'd8, 32'd2, 1'b0, 3'd0, 32'd0);
        do_op(3'd0, 32'd1234567, 32'd89, 1'b1, 3'd5, 32'h1234);
        do_op(3'd4, 32'hABCD, 32'd0, 1'b0, 3'd0, 32'd0);
        do_op(3'd6, 32'h5555, 32'd1, 1'b0, 3'd0, 32'd0);
        do_op(3'd7, 32'h6666, 32'd1, 1'b0, 3'd0, 32'd0);

        for (int k = 0; k < 80; k++) begin
            do_op(3'($urandom_range(0, 7)), rnd_val(), rnd_val(),
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  $urandom);
        end

        do_op(3'd4, 32'h1111_2222, 32'd0, 1'b0, 3'd0, 32'd0);
        reset_mid_op();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
